// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_sequencer                                                 |
// | Description : Fetch-stage program-counter sequencer. Handles interrupts,   |
// |               calls, branches, stalls and a multi-beat return-address      |
// |               load assembled from DATA_W-bit memory beats (MSB first).     |
// |               Interrupts seen during a return load are latched and         |
// |               serviced once the load completes.                            |
// |               Optional macro PC_SEQ_EPC_EN adds the epc output and the     |
// |               eret input (exception PC capture / return).                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int PC_W         = 32,
  parameter int DATA_W       = 16,
  parameter int RESET_VECTOR = 32,
  parameter int INT_VECTOR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_addr,
  input  logic              call_valid,
  input  logic [PC_W-1:0]   call_addr,
  input  logic              int_req,
  input  logic              ret_start,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
`ifdef PC_SEQ_EPC_EN
  input  logic              eret,
  output logic [PC_W-1:0]   epc,
`endif
  output logic [PC_W-1:0]   pc,
  output logic              ret_busy,
  output logic              int_ack,
  output logic              redirect
);

  localparam int BEATS = PC_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_RET_LOAD = 1'b1;

  localparam logic [PC_W-1:0]  C_PC_RST   = PC_W'(RESET_VECTOR - 1);
  localparam logic [PC_W-1:0]  C_INT_VEC  = PC_W'(INT_VECTOR);
  localparam logic [PC_W-1:0]  C_PC_ONE   = PC_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [0:0]        r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PC_W-1:0]   r_shadow, w_shadow_nxt, w_merged;
  logic              r_int_pending, w_pend_nxt;
  logic              r_int_ack, w_ack_nxt;
  logic              r_redirect, w_redir_nxt;
  logic              w_int, w_eret, w_last_beat;
  int                w_base;

`ifdef PC_SEQ_EPC_EN
  logic [PC_W-1:0]   r_epc, w_epc_nxt, w_epc_capture;
  assign w_eret = eret;
  assign epc    = r_epc;
  // Address of the instruction that would have run had the interrupt not been taken
  always_comb begin
    w_epc_capture = r_pc + C_PC_ONE;
    if (r_int_pending)     w_epc_capture = r_pc;
    else if (call_valid)   w_epc_capture = call_addr;
    else if (branch_taken) w_epc_capture = branch_addr;
    else if (stall)        w_epc_capture = r_pc;
  end
`else
  assign w_eret = 1'b0;
`endif

  assign w_int       = int_req | r_int_pending;
  assign w_last_beat = mem_valid && (r_cnt == '0);

  // Shadow value with the current beat merged in, so completion uses this edge's beat
  always_comb begin
    w_base   = int'(r_cnt) * DATA_W;
    w_merged = r_shadow;
    w_merged[w_base +: DATA_W] = mem_data;
  end

  // State and datapath registers; updates on the falling edge to match fetch timing
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_pc          <= C_PC_RST;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_int_pending <= 1'b0;
      r_int_ack     <= 1'b0;
      r_redirect    <= 1'b0;
`ifdef PC_SEQ_EPC_EN
      r_epc         <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_shadow      <= w_shadow_nxt;
      r_int_pending <= w_pend_nxt;
      r_int_ack     <= w_ack_nxt;
      r_redirect    <= w_redir_nxt;
`ifdef PC_SEQ_EPC_EN
      r_epc         <= w_epc_nxt;
`endif
    end
  end

  // Next-state: a return load starts only if nothing of higher priority fires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (!w_int && !w_eret && !call_valid && ret_start)
          w_state_nxt = S_RET_LOAD;
      end
      S_RET_LOAD: begin
        if (w_last_beat)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Datapath / output next values following the per-state priority order
  always_comb begin
    w_pc_nxt     = r_pc;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_pend_nxt   = r_int_pending;
    w_ack_nxt    = 1'b0;
    w_redir_nxt  = 1'b0;
`ifdef PC_SEQ_EPC_EN
    w_epc_nxt    = r_epc;
`endif
    case (r_state)
      S_RUN: begin
        if (w_int) begin
          w_pc_nxt    = C_INT_VEC;
          w_ack_nxt   = 1'b1;
          w_redir_nxt = 1'b1;
          w_pend_nxt  = 1'b0;
`ifdef PC_SEQ_EPC_EN
          w_epc_nxt   = w_epc_capture;
`endif
        end else if (w_eret) begin
`ifdef PC_SEQ_EPC_EN
          w_pc_nxt    = r_epc;
`endif
          w_redir_nxt = 1'b1;
        end else if (call_valid) begin
          w_pc_nxt    = call_addr;
          w_redir_nxt = 1'b1;
        end else if (ret_start) begin
          w_cnt_nxt    = C_CNT_LAST;
          w_shadow_nxt = '0;
        end else if (branch_taken) begin
          w_pc_nxt    = branch_addr;
          w_redir_nxt = 1'b1;
        end else if (!stall) begin
          w_pc_nxt = r_pc + C_PC_ONE;
        end
      end
      S_RET_LOAD: begin
        if (int_req)
          w_pend_nxt = 1'b1;
        if (mem_valid) begin
          w_shadow_nxt = w_merged;
          if (w_last_beat) begin
            w_pc_nxt    = w_merged;
            w_redir_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  assign pc       = r_pc;
  assign ret_busy = (r_state == S_RET_LOAD);
  assign int_ack  = r_int_ack;
  assign redirect = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                              |
// | Description : Self-checking bench for pc_sequencer: directed scenarios     |
// |               followed by randomized traffic, compared every falling edge  |
// |               against a behavioural model. PC_SEQ_EPC_EN adds epc/eret.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int PC_W         = 32;
  localparam int DATA_W       = 16;
  localparam int RESET_VECTOR = 32;
  localparam int INT_VECTOR   = 0;
  localparam int BEATS        = PC_W / DATA_W;

  logic              clk = 1'b0;
  logic              reset, stall, branch_taken, call_valid, int_req, ret_start, mem_valid;
  logic [PC_W-1:0]   branch_addr, call_addr;
  logic [DATA_W-1:0] mem_data;
  logic [PC_W-1:0]   pc;
  logic              ret_busy, int_ack, redirect;
`ifdef PC_SEQ_EPC_EN
  logic              eret;
  logic [PC_W-1:0]   epc;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [PC_W-1:0] m_pc, m_acc, m_epc;
  logic            m_busy, m_ack, m_redir, m_pend;
  int              m_left;

  pc_sequencer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RESET_VECTOR(RESET_VECTOR), .INT_VECTOR(INT_VECTOR)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .call_valid(call_valid), .call_addr(call_addr),
    .int_req(int_req), .ret_start(ret_start), .mem_valid(mem_valid), .mem_data(mem_data),
`ifdef PC_SEQ_EPC_EN
    .eret(eret), .epc(epc),
`endif
    .pc(pc), .ret_busy(ret_busy), .int_ack(int_ack), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    stall = 1'b0; branch_taken = 1'b0; call_valid = 1'b0; int_req = 1'b0;
    ret_start = 1'b0; mem_valid = 1'b0; branch_addr = '0; call_addr = '0; mem_data = '0;
`ifdef PC_SEQ_EPC_EN
    eret = 1'b0;
`endif
  endtask

  // One falling edge of the architectural behaviour
  task automatic model_edge();
    logic do_eret;
`ifdef PC_SEQ_EPC_EN
    do_eret = eret;
`else
    do_eret = 1'b0;
`endif
    if (reset) begin
      m_pc = PC_W'(RESET_VECTOR - 1); m_busy = 0; m_ack = 0; m_redir = 0;
      m_pend = 0; m_left = 0; m_acc = '0; m_epc = '0;
    end else if (!m_busy) begin
      m_ack = 0; m_redir = 0;
      if (int_req || m_pend) begin
        if (m_pend)            m_epc = m_pc;
        else if (call_valid)   m_epc = call_addr;
        else if (branch_taken) m_epc = branch_addr;
        else if (stall)        m_epc = m_pc;
        else                   m_epc = m_pc + 1;
        m_pc = PC_W'(INT_VECTOR); m_ack = 1; m_redir = 1; m_pend = 0;
      end else if (do_eret) begin
        m_pc = m_epc; m_redir = 1;
      end else if (call_valid) begin
        m_pc = call_addr; m_redir = 1;
      end else if (ret_start) begin
        m_busy = 1; m_left = BEATS; m_acc = '0;
      end else if (branch_taken) begin
        m_pc = branch_addr; m_redir = 1;
      end else if (!stall) begin
        m_pc = m_pc + 1;
      end
    end else begin
      m_ack = 0; m_redir = 0;
      if (int_req) m_pend = 1;
      if (mem_valid) begin
        m_acc  = (m_acc << DATA_W) | PC_W'(mem_data);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_pc = m_acc; m_redir = 1; m_busy = 0;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_edge();
    #1;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".ret_busy"}, PC_W'(ret_busy), PC_W'(m_busy));
    chk({tag, ".int_ack"}, PC_W'(int_ack), PC_W'(m_ack));
    chk({tag, ".redirect"}, PC_W'(redirect), PC_W'(m_redir));
`ifdef PC_SEQ_EPC_EN
    chk({tag, ".epc"}, epc, m_epc);
`endif
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    // Reset and free-running start
    step("rst0");
    step("rst1");
    chk("rst.pc_const", pc, 32'd31);
    reset = 1'b0;
    step("run0"); chk("run0.const", pc, 32'd32);
    step("run1"); chk("run1.const", pc, 32'd33);
    step("run2"); chk("run2.const", pc, 32'd34);
    // Stall then branch
    branch_taken = 1'b1; branch_addr = 32'd40; step("br40"); clear_in();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall"); chk("stall.const", pc, 32'd40);
    end
    clear_in(); branch_taken = 1'b1; branch_addr = 32'h100; step("br100");
    chk("br100.const", pc, 32'h100); chk("br100.redir", PC_W'(redirect), 32'd1);
    // Return load with a gap
    clear_in(); branch_taken = 1'b1; branch_addr = 32'd50; step("br50");
    clear_in(); ret_start = 1'b1; step("ret.start"); chk("ret.start.busy", PC_W'(ret_busy), 32'd1);
    clear_in(); mem_valid = 1'b1; mem_data = 16'h0000; step("ret.b0");
    clear_in(); step("ret.gap"); chk("ret.gap.pc", pc, 32'd50);
    mem_valid = 1'b1; mem_data = 16'h0080; step("ret.b1");
    chk("ret.done.pc", pc, 32'h80); chk("ret.done.busy", PC_W'(ret_busy), 32'd0);
    // Interrupt during final beat is deferred
    clear_in(); ret_start = 1'b1; step("ri.start");
    clear_in(); mem_valid = 1'b1; step("ri.b0");
    mem_data = 16'h0080; int_req = 1'b1; step("ri.b1"); chk("ri.b1.pc", pc, 32'h80);
    clear_in(); step("ri.svc");
    chk("ri.svc.pc", pc, 32'h0); chk("ri.svc.ack", PC_W'(int_ack), 32'd1);
    // Interrupt beats call
    int_req = 1'b1; call_valid = 1'b1; call_addr = 32'h200; step("intcall");
    chk("intcall.pc", pc, 32'h0); chk("intcall.ack", PC_W'(int_ack), 32'd1);
    clear_in(); step("intcall.after"); chk("intcall.after.pc", pc, 32'h1);
    // Wrap
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; step("wrap.br");
    clear_in(); step("wrap"); chk("wrap.const", pc, 32'h0);
    // Reset mid-load discards the partial value
    ret_start = 1'b1; step("rml.start");
    clear_in(); mem_valid = 1'b1; mem_data = 16'hABCD; step("rml.b0");
    clear_in(); reset = 1'b1; step("rml.rst"); chk("rml.rst.busy", PC_W'(ret_busy), 32'd0);
    reset = 1'b0; step("rml.run");
`ifdef PC_SEQ_EPC_EN
    branch_taken = 1'b1; branch_addr = 32'h44; step("epc.br");
    clear_in(); int_req = 1'b1; step("epc.int"); chk("epc.capture", epc, 32'h45);
    clear_in(); eret = 1'b1; step("epc.eret"); chk("epc.ret.pc", pc, 32'h45);
    clear_in();
`endif
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      stall        = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 15);
      call_valid   = ($urandom_range(0, 99) < 8);
      int_req      = ($urandom_range(0, 99) < 5);
      ret_start    = ($urandom_range(0, 99) < 12);
      mem_valid    = ($urandom_range(0, 99) < 50);
      branch_addr  = $urandom;
      call_addr    = $urandom;
      mem_data     = DATA_W'($urandom);
`ifdef PC_SEQ_EPC_EN
      eret         = ($urandom_range(0, 99) < 5);
`endif
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
